// File: rtl/vga_pkg.sv
// vga_pkg: FSM states, 16-bit slot geometry, mode bit positions and bar-to-register slot mapping
package vga_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_COMMIT} state_t;
  localparam int SLOT_W = 16;
  localparam int NUM_REGS = 4;
  localparam int NUM_BARS = 8;
  localparam int MODE_ROT = 0;
  localparam int MODE_FRZ = 1;
  localparam int EVEN_LSB = SLOT_W;
  localparam int ODD_LSB = 0;
  function automatic int slot_reg(input int k);
    return k / 2;
  endfunction
  function automatic int slot_lsb(input int k);
    return (k % 2 == 0) ? EVEN_LSB : ODD_LSB;
  endfunction
endpackage

// File: rtl/vga_vs_sync.sv
// vga_vs_sync: STAGES-deep synchronizer for async vga_vs (CLK, RST, vga_vs in) with a one-cycle frame_edge pulse on its rising edge
module vga_vs_sync #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  input  logic vga_vs,
  output logic frame_edge
);
  logic [STAGES-1:0] sync;
  logic last;
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync <= '1;
      last <= 1'b1;
    end else begin
      sync <= {sync[STAGES-2:0], vga_vs};
      last <= sync[STAGES-1];
    end
  end
  assign frame_edge = sync[STAGES-1] & ~last;
endmodule

// File: rtl/vga_bar_ctrl.sv
// vga_bar_ctrl: shadowed bar colours (wr_*, mode_*) committed/rotated into reg0..reg3 on vga_vs frame boundaries; pending and frame_cnt report status
module vga_bar_ctrl
  import vga_pkg::*;
#(
  parameter int ROT_FRAMES = 60,
  parameter int SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_en,
  input  logic [1:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        mode_wr,
  input  logic [1:0]  mode_data,
  input  logic        vga_vs,
  output logic [31:0] reg0,
  output logic [31:0] reg1,
  output logic [31:0] reg2,
  output logic [31:0] reg3,
  output logic        pending,
  output logic [7:0]  frame_cnt
);
  localparam logic [7:0] CNT_LAST = 8'(ROT_FRAMES - 1);
  state_t state, state_nxt;
  logic [31:0] shadow [NUM_REGS];
  logic [SLOT_W-1:0] bar [NUM_BARS];
  logic [1:0] mode;
  logic frame_edge, boundary, rot_en, commit_due, rot_wrap;
  vga_vs_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .CLK(CLK),
    .RST(RST),
    .vga_vs(vga_vs),
    .frame_edge(frame_edge)
  );
  assign rot_en = mode[MODE_ROT];
  assign boundary = frame_edge & ~mode[MODE_FRZ];
  assign commit_due = boundary && (state == ST_PEND);
  assign rot_wrap = boundary && rot_en && !commit_due && (frame_cnt == CNT_LAST);
  assign pending = (state != ST_IDLE);
  always_comb begin
    state_nxt = state;
    state_nxt = (state == ST_IDLE) ? (wr_en ? ST_PEND : ST_IDLE)
              : (state == ST_PEND) ? (commit_due ? ST_COMMIT : ST_PEND)
              : (wr_en ? ST_PEND : ST_IDLE);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      mode <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
      for (int k = 0; k < NUM_BARS; k++) bar[k] <= '0;
    end else begin
      state <= state_nxt;
      if (wr_en) shadow[wr_addr] <= wr_data;
      if (mode_wr) mode <= mode_data;
      frame_cnt <= ((mode_wr && !mode_data[MODE_ROT]) || commit_due || rot_wrap) ? '0
                 : (boundary && rot_en) ? frame_cnt + 8'd1
                 : frame_cnt;
      if (state == ST_COMMIT) begin
        for (int k = 0; k < NUM_BARS; k++) bar[k] <= shadow[slot_reg(k)][slot_lsb(k) +: SLOT_W];
      end else if (rot_wrap) begin
        for (int k = 0; k < NUM_BARS; k++) bar[k] <= bar[(k + 1) % NUM_BARS];
      end
    end
  end
  assign reg0 = {bar[0], bar[1]};
  assign reg1 = {bar[2], bar[3]};
  assign reg2 = {bar[4], bar[5]};
  assign reg3 = {bar[6], bar[7]};
endmodule

// File: tb/tb_vga_bar_ctrl.sv
// tb_vga_bar_ctrl: table, directed and random checks of vga_bar_ctrl against a frame-level reference model
module tb_vga_bar_ctrl;
  localparam int R = 2;
  logic CLK = 1'b0;
  logic RST, wr_en, mode_wr, vga_vs;
  logic [1:0] wr_addr, mode_data;
  logic [31:0] wr_data, reg0, reg1, reg2, reg3;
  logic pending;
  logic [7:0] frame_cnt;
  int tests = 0;
  int fails = 0;
  logic [15:0] m_bar [8];
  logic [31:0] m_sh [4];
  logic m_pend, m_commit;
  logic [1:0] m_mode;
  logic [7:0] m_cnt;
  logic h [4];
  typedef struct {
    int n;
    logic wr;
    logic [1:0] a;
    logic [31:0] d;
    logic vs;
    logic [31:0] e_reg0;
    logic e_pend;
  } vec_t;
  vec_t tbl [7];
  vga_bar_ctrl #(.ROT_FRAMES(R), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mode_wr(mode_wr), .mode_data(mode_data), .vga_vs(vga_vs),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .pending(pending), .frame_cnt(frame_cnt)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] m_reg(input int i);
    return {m_bar[2*i], m_bar[2*i+1]};
  endfunction
  task automatic model_edge();
    logic bnd, pend_pre, com_pre;
    logic [31:0] sh_pre [4];
    logic [15:0] tmp [8];
    if (RST) begin
      for (int k = 0; k < 8; k++) m_bar[k] = '0;
      for (int i = 0; i < 4; i++) m_sh[i] = '0;
      m_pend = 0; m_commit = 0; m_mode = '0; m_cnt = '0;
      for (int i = 0; i < 4; i++) h[i] = 1'b1;
      return;
    end
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = vga_vs;
    bnd = h[2] && !h[3] && !m_mode[1];
    sh_pre = m_sh; pend_pre = m_pend; com_pre = m_commit;
    m_commit = 0;
    if (com_pre) begin
      for (int k = 0; k < 8; k++) m_bar[k] = (k % 2 == 0) ? sh_pre[k/2][31:16] : sh_pre[k/2][15:0];
      m_pend = 0;
    end
    if (wr_en) begin m_sh[wr_addr] = wr_data; m_pend = 1; end
    if (bnd && pend_pre && !com_pre) begin
      m_commit = 1; m_cnt = 0;
    end else if (bnd && m_mode[0]) begin
      if (m_cnt == 8'(R - 1)) begin
        tmp = m_bar;
        for (int k = 0; k < 8; k++) m_bar[k] = tmp[(k + 1) % 8];
        m_cnt = 0;
      end else m_cnt = m_cnt + 1;
    end
    if (mode_wr) begin m_mode = mode_data; if (!mode_data[0]) m_cnt = 0; end
  endtask
  task automatic tick();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check_model(input string name);
    logic [136:0] act, exp;
    act = {reg0, reg1, reg2, reg3, pending, frame_cnt};
    exp = {m_reg(0), m_reg(1), m_reg(2), m_reg(3), m_pend || m_commit, m_cnt};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL model %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic set_mode(input logic [1:0] m);
    mode_wr = 1; mode_data = m;
    tick();
    mode_wr = 0;
  endtask
  task automatic frame();
    vga_vs = 0;
    repeat (8) tick();
    vga_vs = 1;
    repeat (4) tick();
    check_model("frame");
  endtask
  initial begin
    tbl[0] = '{1, 1'b1, 2'd0, 32'hF800_07E0, 1'b1, 32'h0, 1'b1};
    tbl[1] = '{100, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1};
    tbl[2] = '{1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0, 1'b1};
    tbl[3] = '{1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0, 1'b1};
    tbl[4] = '{1, 1'b0, 2'd0, 32'h0, 1'b1, 32'h0, 1'b1};
    tbl[5] = '{1, 1'b0, 2'd0, 32'h0, 1'b1, 32'hF800_07E0, 1'b0};
    tbl[6] = '{5, 1'b0, 2'd0, 32'h0, 1'b1, 32'hF800_07E0, 1'b0};
    RST = 1; wr_en = 0; wr_addr = 0; wr_data = 0; mode_wr = 0; mode_data = 0; vga_vs = 1;
    @(negedge CLK);
    tick(); tick();
    RST = 0;
    chk("reset reg0", reg0, 32'h0);
    chk("reset reg3", reg3, 32'h0);
    chk("reset pending", 32'(pending), 32'h0);
    chk("reset frame_cnt", 32'(frame_cnt), 32'h0);
    for (int i = 0; i < 7; i++) begin
      wr_en = tbl[i].wr; wr_addr = tbl[i].a; wr_data = tbl[i].d; vga_vs = tbl[i].vs;
      tick();
      wr_en = 0;
      repeat (tbl[i].n - 1) tick();
      chk($sformatf("tbl%0d reg0", i), reg0, tbl[i].e_reg0);
      chk($sformatf("tbl%0d pending", i), 32'(pending), 32'(tbl[i].e_pend));
      check_model($sformatf("tbl%0d", i));
    end
    chk("commit reg1", reg1, 32'h0);
    wr(2'd2, 32'hAAAA_5555);
    vga_vs = 0;
    repeat (8) tick();
    vga_vs = 1;
    repeat (3) tick();
    chk("pre-commit pending", 32'(pending), 32'h1);
    wr(2'd1, 32'h001F_001F);
    chk("commit-cycle reg2", reg2, 32'hAAAA_5555);
    chk("commit-cycle reg1 excluded", reg1, 32'h0);
    chk("commit-cycle pending", 32'(pending), 32'h1);
    frame();
    chk("next-frame reg1", reg1, 32'h001F_001F);
    chk("next-frame pending", 32'(pending), 32'h0);
    wr(2'd3, 32'h1234_5678);
    repeat (200) tick();
    chk("no-boundary reg3", reg3, 32'h0);
    chk("no-boundary pending", 32'(pending), 32'h1);
    RST = 1;
    tick();
    RST = 0;
    chk("mid-reset reg1", reg1, 32'h0);
    chk("mid-reset pending", 32'(pending), 32'h0);
    frame();
    chk("post-reset reg3", reg3, 32'h0);
    chk("post-reset pending", 32'(pending), 32'h0);
    wr(2'd0, 32'h0001_0002); wr(2'd1, 32'h0003_0004);
    wr(2'd2, 32'h0005_0006); wr(2'd3, 32'h0007_0008);
    frame();
    chk("bars reg0", reg0, 32'h0001_0002);
    set_mode(2'b01);
    frame();
    chk("rot cnt1", 32'(frame_cnt), 32'h1);
    chk("rot none reg0", reg0, 32'h0001_0002);
    frame();
    chk("rot cnt0", 32'(frame_cnt), 32'h0);
    chk("rot reg0", reg0, 32'h0002_0003);
    chk("rot reg3", reg3, 32'h0008_0001);
    frame();
    chk("pre-freeze cnt", 32'(frame_cnt), 32'h1);
    set_mode(2'b11);
    wr(2'd0, 32'hDEAD_BEEF);
    repeat (3) frame();
    chk("freeze reg0", reg0, 32'h0002_0003);
    chk("freeze cnt", 32'(frame_cnt), 32'h1);
    chk("freeze pending", 32'(pending), 32'h1);
    set_mode(2'b01);
    frame();
    chk("unfreeze reg0", reg0, 32'hDEAD_BEEF);
    chk("unfreeze cnt", 32'(frame_cnt), 32'h0);
    frame();
    set_mode(2'b00);
    chk("rot-off cnt", 32'(frame_cnt), 32'h0);
    begin
      int vs_left = 10;
      for (int c = 0; c < 4000; c++) begin
        wr_en = ($urandom % 4) == 0;
        wr_addr = 2'($urandom);
        wr_data = $urandom;
        mode_wr = ($urandom % 40) == 0;
        mode_data = 2'($urandom);
        RST = ($urandom % 700) == 0;
        if (--vs_left == 0) begin
          vga_vs = ~vga_vs;
          vs_left = vga_vs ? int'($urandom_range(5, 40)) : int'($urandom_range(3, 20));
        end
        tick();
        check_model("random");
      end
      wr_en = 0; mode_wr = 0; RST = 0;
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
